// File: rtl/calc_pkg.sv
// Shared types for the RPN stack engine.
//   op_e    : command opcodes accepted on cmd_op
//   err_e   : error classification reported on err_code
//   state_e : engine control states
package calc_pkg;

   typedef enum logic [2:0] {
      OP_PUSH = 3'd0,
      OP_NEG  = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_MUL  = 3'd4,
      OP_DUP  = 3'd5,
      OP_SWAP = 3'd6,
      OP_DROP = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_UNDERFLOW = 2'd1,
      ERR_OVERFLOW  = 2'd2
   } err_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_e;

   // Ops that remove one entry and therefore may need NOS refilled from RAM.
   function automatic logic is_pop(op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DROP);
   endfunction

endpackage

// File: rtl/rpn_stack_engine_if.sv
// Command / status bundle of the RPN stack engine.
//   cmd_valid, cmd_op, cmd_data : command from the source (master)
//   cmd_ready                   : engine can take a command this cycle
//   top, cnt                    : current top-of-stack and stack depth
//   err, err_code               : one-cycle rejection pulse and its cause
interface rpn_stack_engine_if
   import calc_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = 10
);
   logic          cmd_valid;
   logic          cmd_ready;
   op_e           cmd_op;
   logic [W-1:0]  cmd_data;
   logic [W-1:0]  top;
   logic [CW-1:0] cnt;
   logic          err;
   err_e          err_code;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, top, cnt, err, err_code
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, top, cnt, err, err_code
   );
endinterface

// File: rtl/rpn_stack_engine_stack_ram.sv
// Spill storage for stack entries below NOS.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : synchronous read port, rdata updates the cycle after re
// No reset: contents are only read back after having been written.
module stack_ram #(
   parameter int W     = 16,
   parameter int DEPTH = 998,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack calculator. TOS/NOS live in flops, deeper entries in stack_ram.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of rpn_stack_engine_if (command handshake + status)
//
//   state     | meaning
//   ST_IDLE   | ready for a command
//   ST_REFILL | a pop was accepted at depth>=3; NOS is loaded from RAM read data
module rpn_stack_engine
   import calc_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 1000
) (
   input  logic              clk,
   input  logic              rst,
   rpn_stack_engine_if.slave bus
);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int RAM_D = DEPTH - 2;
   localparam int AW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] TWO_C   = CW'(2);
   localparam logic [CW-1:0] THREE_C = CW'(3);

   state_e        state_q, state_d;
   logic [W-1:0]  tos_q, tos_d;
   logic [W-1:0]  nos_q, nos_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   err_e          err_code_q, err_code_d;

   logic          ram_we, ram_re;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [W-1:0]  ram_rdata;

   logic          accept;
   logic          legal;
   err_e          bad_code;

   assign accept = bus.cmd_valid && (state_q == ST_IDLE);

   // Legality depends only on opcode and current depth.
   always_comb begin
      legal    = 1'b1;
      bad_code = ERR_UNDERFLOW;
      unique case (bus.cmd_op)
         OP_PUSH: begin
            legal    = cnt_q < DEPTH_C;
            bad_code = ERR_OVERFLOW;
         end
         OP_DUP: begin
            legal    = (cnt_q >= ONE_C) && (cnt_q < DEPTH_C);
            bad_code = (cnt_q == '0) ? ERR_UNDERFLOW : ERR_OVERFLOW;
         end
         OP_NEG, OP_DROP:                   legal = cnt_q >= ONE_C;
         OP_ADD, OP_SUB, OP_MUL, OP_SWAP:   legal = cnt_q >= TWO_C;
         default:                           legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = ST_IDLE;
      tos_d      = tos_q;
      nos_d      = nos_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      ram_waddr  = AW'(cnt_q - TWO_C);
      ram_raddr  = AW'(cnt_q - THREE_C);

      if (state_q == ST_REFILL) begin
         nos_d = ram_rdata;
      end else if (accept && !legal) begin
         err_d      = 1'b1;
         err_code_d = bad_code;
      end else if (accept) begin
         unique case (bus.cmd_op)
            OP_PUSH, OP_DUP: begin
               ram_we = cnt_q >= TWO_C;
               nos_d  = tos_q;
               tos_d  = (bus.cmd_op == OP_PUSH) ? bus.cmd_data : tos_q;
               cnt_d  = cnt_q + ONE_C;
            end
            OP_NEG:  tos_d = W'(0) - tos_q;
            OP_SWAP: begin
               tos_d = nos_q;
               nos_d = tos_q;
            end
            OP_ADD:  tos_d = nos_q + tos_q;
            OP_SUB:  tos_d = nos_q - tos_q;
            OP_MUL:  tos_d = W'(nos_q * tos_q);
            OP_DROP: tos_d = nos_q;
            default: ;
         endcase

         if (is_pop(bus.cmd_op)) begin
            cnt_d = cnt_q - ONE_C;
            if (cnt_q >= THREE_C) begin
               ram_re  = 1'b1;
               state_d = ST_REFILL;
            end else begin
               nos_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tos_q      <= '0;
         nos_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         tos_q      <= tos_d;
         nos_q      <= nos_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   stack_ram #(
      .W     (W),
      .DEPTH (RAM_D),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (nos_q),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.top       = (cnt_q == '0) ? '0 : tos_q;
   assign bus.cnt       = cnt_q;
   assign bus.err       = err_q;
   assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed bench for rpn_stack_engine at W=16, DEPTH=4.
module tb_rpn_stack_engine;
   import calc_pkg::*;

   localparam int W     = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rpn_stack_engine_if #(.W(W), .CW(CW)) bus ();

   rpn_stack_engine #(.W(W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;

   always @(posedge clk)
      if (!rst && bus.cmd_valid && bus.cmd_ready) acc_cnt++;

   typedef struct {
      bit           do_rst;
      op_e          op;
      logic [15:0]  data;
      logic [15:0]  e_top;
      int           e_cnt;
      bit           e_err;
      err_e         e_code;
      bit           e_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, op_e op, logic [15:0] d, logic [15:0] t, int c,
                               bit e, err_e code, bit rdy);
      vec_t v;
      v.do_rst = r; v.op = op; v.data = d; v.e_top = t; v.e_cnt = c;
      v.e_err = e; v.e_code = code; v.e_rdy = rdy;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Presents one command, waits (bounded) for ready, returns #1 after the accept edge.
   task automatic send(op_e op, logic [15:0] d);
      int n;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      n = 0;
      while (!bus.cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n == 10) begin
         total++; bad++;
         $display("FAIL ready_timeout: got ready=0 want ready=1 within 10 cycles");
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_PUSH;
      bus.cmd_data  = '0;

      // 1: basic add
      vecs.push_back(mk(1, OP_PUSH, 16'd5,    16'd5,    1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd7,    16'd7,    2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_ADD,  16'd0,    16'd12,   1, 0, ERR_NONE, 1));
      // 2: deep pops with refill
      vecs.push_back(mk(1, OP_PUSH, 16'd3,    16'd3,    1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd4,    16'd4,    2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd5,    16'd5,    3, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd6,    16'd6,    4, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_MUL,  16'd0,    16'd30,   3, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_SUB,  16'd0,    16'hFFE6, 2, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_ADD,  16'd0,    16'hFFE9, 1, 0, ERR_NONE, 1));
      // 3: overflow, then drain through RAM
      vecs.push_back(mk(1, OP_PUSH, 16'd1,    16'd1,    1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd2,    16'd2,    2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd3,    16'd3,    3, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd4,    16'd4,    4, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd9,    16'd4,    4, 1, ERR_OVERFLOW, 1));
      vecs.push_back(mk(0, OP_DUP,  16'd0,    16'd4,    4, 1, ERR_OVERFLOW, 1));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd3,    3, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd2,    2, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd1,    1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd0,    0, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd0,    0, 1, ERR_UNDERFLOW, 1));
      // 4: underflow cases
      vecs.push_back(mk(1, OP_ADD,  16'd0,    16'd0,    0, 1, ERR_UNDERFLOW, 1));
      vecs.push_back(mk(0, OP_NEG,  16'd0,    16'd0,    0, 1, ERR_UNDERFLOW, 1));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd0,    0, 1, ERR_UNDERFLOW, 1));
      vecs.push_back(mk(0, OP_DUP,  16'd0,    16'd0,    0, 1, ERR_UNDERFLOW, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd2,    16'd2,    1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_SWAP, 16'd0,    16'd2,    1, 1, ERR_UNDERFLOW, 1));
      vecs.push_back(mk(0, OP_ADD,  16'd0,    16'd2,    1, 1, ERR_UNDERFLOW, 1));
      // 5: wrap/truncation and stack shuffles
      vecs.push_back(mk(1, OP_PUSH, 16'h8000, 16'h8000, 1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_NEG,  16'd0,    16'h8000, 1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'h0100, 16'h0100, 2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_MUL,  16'd0,    16'h0000, 1, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd5,    16'd5,    2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_SWAP, 16'd0,    16'd0,    2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_DUP,  16'd0,    16'd0,    3, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_DROP, 16'd0,    16'd0,    2, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_SWAP, 16'd0,    16'd5,    2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_DUP,  16'd0,    16'd5,    3, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_DUP,  16'd0,    16'd5,    4, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_PUSH, 16'd1,    16'd5,    4, 1, ERR_OVERFLOW, 1));
      vecs.push_back(mk(0, OP_SUB,  16'd0,    16'd0,    3, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_ADD,  16'd0,    16'd5,    2, 0, ERR_NONE, 0));
      vecs.push_back(mk(0, OP_NEG,  16'd0,    16'hFFFB, 2, 0, ERR_NONE, 1));
      vecs.push_back(mk(0, OP_SUB,  16'd0,    16'h0005, 1, 0, ERR_NONE, 1));

      // reset state
      do_reset();
      @(posedge clk); #1;
      check("rst_top",   32'(bus.top), 32'd0);
      check("rst_cnt",   32'(bus.cnt), 32'd0);
      check("rst_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_err",   32'(bus.err), 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         send(vecs[i].op, vecs[i].data);
         check($sformatf("v%0d_top", i),   32'(bus.top),      32'(vecs[i].e_top));
         check($sformatf("v%0d_cnt", i),   32'(bus.cnt),      32'(vecs[i].e_cnt));
         check($sformatf("v%0d_err", i),   32'(bus.err),      32'(vecs[i].e_err));
         check($sformatf("v%0d_code", i),  32'(bus.err_code), 32'(vecs[i].e_code));
         check($sformatf("v%0d_ready", i), 32'(bus.cmd_ready), 32'(vecs[i].e_rdy));
      end

      // 6a: reset during REFILL aborts it
      do_reset();
      send(OP_PUSH, 16'd1);
      send(OP_PUSH, 16'd2);
      send(OP_PUSH, 16'd3);
      send(OP_DROP, 16'd0);
      check("refill_pending", 32'(bus.cmd_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_refill_cnt",   32'(bus.cnt), 32'd0);
      check("rst_refill_top",   32'(bus.top), 32'd0);
      check("rst_refill_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_refill_err",   32'(bus.err), 32'd0);

      // 6b: valid held high continuously across refill stalls
      begin
         op_e         ops[9];
         logic [15:0] dat[9];
         ops = '{OP_PUSH, OP_PUSH, OP_PUSH, OP_ADD, OP_PUSH, OP_MUL, OP_PUSH, OP_SUB, OP_ADD};
         dat = '{16'd10, 16'd20, 16'd30, 16'd0, 16'd4, 16'd0, 16'd7, 16'd0, 16'd0};
         @(negedge clk);
         acc_cnt = 0;
         for (int k = 0; k < 9; k++) begin
            int n;
            if (k != 0) @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = ops[k];
            bus.cmd_data  = dat[k];
            n = 0;
            while (!bus.cmd_ready && n < 10) begin
               @(negedge clk);
               n++;
            end
            if (n == 10) begin
               total++; bad++;
               $display("FAIL b2b_timeout: got ready=0 want ready=1 at cmd %0d", k);
            end
            @(posedge clk);
         end
         #1;
         bus.cmd_valid = 1'b0;
         @(negedge clk);
         check("b2b_accepts", 32'(acc_cnt), 32'd9);
         check("b2b_top",     32'(bus.top), 32'd203);
         check("b2b_cnt",     32'(bus.cnt), 32'd1);
         check("b2b_err",     32'(bus.err), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
